// File: rtl/mem_resp_pkg.sv
// Shared types and default parameters for the multi-cycle data-memory responder.
package mem_resp_pkg;

  localparam int unsigned DefaultDepthWords = 256;
  localparam int unsigned DefaultLatency    = 4;

  typedef enum logic {
    StIdle,
    StBusy
  } state_e;

  typedef enum logic {
    OpRd = 1'b0,
    OpWr = 1'b1
  } op_e;

endpackage

// File: rtl/mem_array.sv
// Word storage: synchronous write, combinational read, no reset.
module mem_array
  import mem_resp_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = DefaultDepthWords,
  localparam int unsigned Aw = $clog2(DEPTH_WORDS)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [Aw-1:0] addr_i,
  input  logic [15:0]   wdata_i,
  output logic [15:0]   rdata_o
);

  logic [15:0] mem_q [DEPTH_WORDS];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mem_responder.sv
// Multi-cycle memory responder: accepts one word access, stalls for LATENCY cycles,
// then pulses Done with read data.
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = DefaultDepthWords,
  parameter int unsigned LATENCY     = DefaultLatency
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] Addr,
  input  logic [15:0] DataIn,
  input  logic        Rd,
  input  logic        Wr,
  output logic [15:0] DataOut,
  output logic        Done,
  output logic        Stall,
  output logic        err
);

  localparam int unsigned Aw   = $clog2(DEPTH_WORDS);
  localparam int unsigned CntW = $clog2(LATENCY + 1);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [Aw-1:0]   addr_q;
  logic [15:0]     data_q;
  op_e             op_q;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic [15:0]     dout_q, dout_d;

  logic            idle, legal, accept, illegal, complete, mem_we;
  logic [Aw-1:0]   cur_addr;
  logic [15:0]     cur_data, rdata;
  op_e             cur_op, req_op;

  // Upper address bits only select aliases of the same word.
  logic unused_addr;
  assign unused_addr = ^Addr[15:Aw+1];

  assign idle     = (state_q == StIdle);
  assign legal    = (Rd ^ Wr) && !Addr[0];
  assign accept   = idle && legal;
  assign illegal  = idle && (Rd || Wr) && !legal;
  assign req_op   = Wr ? OpWr : OpRd;
  // With LATENCY=1 the access completes on the accepting edge, straight from the inputs.
  assign cur_addr = idle ? Addr[Aw:1] : addr_q;
  assign cur_data = idle ? DataIn : data_q;
  assign cur_op   = idle ? req_op : op_q;
  assign complete = (accept && (LATENCY == 1)) || (!idle && (cnt_q == CntW'(1)));
  assign mem_we   = complete && (cur_op == OpWr);

  mem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_mem_array (
    .clk_i   (clk),
    .we_i    (mem_we),
    .addr_i  (cur_addr),
    .wdata_i (cur_data),
    .rdata_o (rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (accept && (LATENCY > 1)) state_d = StBusy;
      StBusy: if (cnt_q == CntW'(1)) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    Stall = (state_q == StBusy);
  end

  always_comb begin
    cnt_d = cnt_q;
    if (accept && (LATENCY > 1)) begin
      cnt_d = CntW'(LATENCY - 1);
    end else if (!idle) begin
      cnt_d = cnt_q - CntW'(1);
    end
    done_d = complete;
    err_d  = illegal;
    dout_d = (complete && (cur_op == OpRd)) ? rdata : dout_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      addr_q <= '0;
      data_q <= '0;
      op_q   <= OpRd;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      dout_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
      err_q  <= err_d;
      dout_q <= dout_d;
      if (accept) begin
        addr_q <= Addr[Aw:1];
        data_q <= DataIn;
        op_q   <= req_op;
      end
    end
  end

  assign DataOut = dout_q;
  assign Done    = done_q;
  assign err     = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Drives a LATENCY=4 and a LATENCY=1 responder with the same stimulus and checks
// both against a transaction-level model (pending access + word array).
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] addr, din;
  logic        rd, wr;

  logic [15:0] dout4, dout1;
  logic        done4, stall4, err4, done1, stall1, err1;

  always #5 clk = ~clk;

  mem_responder #(
    .DEPTH_WORDS(256),
    .LATENCY    (4)
  ) u_dut4 (
    .clk     (clk),
    .rst     (rst),
    .Addr    (addr),
    .DataIn  (din),
    .Rd      (rd),
    .Wr      (wr),
    .DataOut (dout4),
    .Done    (done4),
    .Stall   (stall4),
    .err     (err4)
  );

  mem_responder #(
    .DEPTH_WORDS(256),
    .LATENCY    (1)
  ) u_dut1 (
    .clk     (clk),
    .rst     (rst),
    .Addr    (addr),
    .DataIn  (din),
    .Rd      (rd),
    .Wr      (wr),
    .DataOut (dout1),
    .Done    (done1),
    .Stall   (stall1),
    .err     (err1)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          lat [2]  = '{4, 1};
  logic [15:0] model [2][256];
  logic        pend [2];
  int          acc [2];
  logic        pwr [2];
  int          pidx [2];
  logic [15:0] pdata [2];
  logic        errn [2];
  logic [15:0] exp_dout [2];

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Called at a negedge: present inputs, advance one cycle, check both DUTs.
  task automatic step(input logic r, input logic w, input logic [15:0] a,
                      input logic [15:0] dat, input logic rs);
    logic        exp_done, exp_stall;
    logic [15:0] g_dout;
    logic        g_done, g_stall, g_err;
    rd = r; wr = w; addr = a; din = dat; rst = rs;
    for (int d = 0; d < 2; d++) begin
      if (rs) begin
        pend[d] = 1'b0; errn[d] = 1'b0; exp_dout[d] = 16'h0;
      end else if (!pend[d] && (r || w)) begin
        if ((r != w) && !a[0]) begin
          pend[d] = 1'b1; acc[d] = cyc; pwr[d] = w;
          pidx[d] = (int'(a) / 2) % 256; pdata[d] = dat; errn[d] = 1'b0;
        end else begin
          errn[d] = 1'b1;
        end
      end else begin
        errn[d] = 1'b0;
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      exp_done  = pend[d] && (cyc == acc[d] + lat[d]);
      exp_stall = pend[d] && (cyc < acc[d] + lat[d]);
      if (exp_done) begin
        if (pwr[d]) model[d][pidx[d]] = pdata[d];
        else exp_dout[d] = model[d][pidx[d]];
        pend[d] = 1'b0;
      end
      g_dout  = (d == 0) ? dout4 : dout1;
      g_done  = (d == 0) ? done4 : done1;
      g_stall = (d == 0) ? stall4 : stall1;
      g_err   = (d == 0) ? err4 : err1;
      check_eq($sformatf("lat%0d Done", lat[d]), {15'h0, g_done}, {15'h0, exp_done});
      check_eq($sformatf("lat%0d Stall", lat[d]), {15'h0, g_stall}, {15'h0, exp_stall});
      check_eq($sformatf("lat%0d err", lat[d]), {15'h0, g_err}, {15'h0, errn[d]});
      check_eq($sformatf("lat%0d DataOut", lat[d]), g_dout, exp_dout[d]);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [15:0] ra, rdat;
    int          sel;
    rst = 1'b1; rd = 1'b0; wr = 1'b0; addr = 16'h0; din = 16'h0;
    for (int d = 0; d < 2; d++) begin
      pend[d] = 1'b0; errn[d] = 1'b0; exp_dout[d] = 16'h0; acc[d] = 0;
    end
    @(negedge clk);
    step(1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
    idle(1);

    // Give every word a known value, with random alias bits above the index.
    for (int i = 0; i < 256; i++) begin
      ra = 16'($urandom) & 16'hFE00;
      step(1'b0, 1'b1, ra | 16'(i * 2), 16'($urandom), 1'b0);
      idle(3);
    end

    // Write then read back.
    step(1'b0, 1'b1, 16'h0010, 16'hBEEF, 1'b0); idle(3);
    step(1'b1, 1'b0, 16'h0010, 16'h0, 1'b0);    idle(4);
    // Request presented while busy.
    step(1'b0, 1'b1, 16'h0030, 16'h7777, 1'b0); idle(1);
    step(1'b1, 1'b0, 16'h0020, 16'h0, 1'b0);    idle(4);
    step(1'b1, 1'b0, 16'h0020, 16'h0, 1'b0);    idle(4);
    // Illegal requests.
    step(1'b1, 1'b1, 16'h0004, 16'hDEAD, 1'b0); idle(4);
    step(1'b1, 1'b0, 16'h0003, 16'h0, 1'b0);    idle(4);
    step(1'b1, 1'b0, 16'h0004, 16'h0, 1'b0);    idle(4);
    // Address wrap.
    step(1'b0, 1'b1, 16'h0202, 16'h1234, 1'b0); idle(3);
    step(1'b1, 1'b0, 16'h0002, 16'h0, 1'b0);    idle(4);
    // Reset in the middle of a write.
    step(1'b0, 1'b1, 16'h0008, 16'h5555, 1'b0); idle(3);
    step(1'b0, 1'b1, 16'h0008, 16'hAAAA, 1'b0); idle(1);
    step(1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
    idle(1);
    step(1'b1, 1'b0, 16'h0008, 16'h0, 1'b0);    idle(4);

    // Back-to-back writes then reads, exercising the single-cycle build.
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 16'(i * 2), 16'($urandom), 1'b0);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 16'(i * 2), 16'h0, 1'b0);
    idle(4);

    // Randomised mix of legal, illegal and idle cycles.
    for (int i = 0; i < 2000; i++) begin
      sel  = int'($urandom_range(0, 99));
      ra   = 16'($urandom);
      rdat = 16'($urandom);
      if ($urandom_range(0, 9) != 0) ra[0] = 1'b0;
      if (sel < 45)      step(1'b1, 1'b0, ra, rdat, 1'b0);
      else if (sel < 80) step(1'b0, 1'b1, ra, rdat, 1'b0);
      else if (sel < 88) step(1'b1, 1'b1, ra, rdat, 1'b0);
      else if (sel < 99) step(1'b0, 1'b0, ra, rdat, 1'b0);
      else begin
        step(1'b0, 1'b0, ra, rdat, 1'b1);
        idle(1);
      end
    end
    idle(5);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
